// File: rtl/timer_display_driver.sv
// Four-digit common-anode 7-segment driver for the count-down timer.
// Scans snapshotted BCD digits, blanks leading zeros, drives DPs and blinks when done.
module timer_display_driver #(
    parameter int unsigned REFRESH_DIV = 2500,
    parameter int unsigned BLINK_DIV   = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int unsigned REF_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    typedef enum logic {INIT, SCAN} state_t;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [3:0] dp;
        logic       blz;
    } snap_t;

    state_t           state_q, state_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_on_q, phase_on_d;
    snap_t            snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    snap_t            live_c;
    logic [3:0]       cur_digit_c;
    logic             blank3_c, blank2_c, blank1_c, cur_blank_c;
    logic [6:0]       glyph_c;

    // g..a active low; non-BCD codes render as a dash
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign live_c = '{d3: digit3, d2: digit2, d1: digit1, d0: digit0,
                      dp: dp_mask, blz: blank_lz};

    // Blanking cascades from the leftmost digit; digit0 always shows
    always_comb begin
        blank3_c = snap_q.blz && (snap_q.d3 == 4'd0);
        blank2_c = blank3_c && (snap_q.d2 == 4'd0);
        blank1_c = blank2_c && (snap_q.d1 == 4'd0);
        case (idx_q)
            2'd0:    begin cur_digit_c = snap_q.d0; cur_blank_c = 1'b0;     end
            2'd1:    begin cur_digit_c = snap_q.d1; cur_blank_c = blank1_c; end
            2'd2:    begin cur_digit_c = snap_q.d2; cur_blank_c = blank2_c; end
            default: begin cur_digit_c = snap_q.d3; cur_blank_c = blank3_c; end
        endcase
        glyph_c = cur_blank_c ? 7'h7F : bcd_to_seg(cur_digit_c);
    end

    always_comb begin
        state_d     = state_q;
        ref_cnt_d   = ref_cnt_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        an_d        = 4'hF;
        seg_d       = 8'hFF;

        case (state_q)
            INIT: begin
                snap_d  = live_c;
                state_d = SCAN;
            end
            default: begin
                if (ref_cnt_q == REF_LAST) begin
                    ref_cnt_d = '0;
                    idx_d     = idx_q + 2'd1;
                    // Snapshot only at the frame boundary so a frame is never torn
                    if (idx_q == 2'd3) begin
                        snap_d = live_c;
                    end
                end else begin
                    ref_cnt_d = ref_cnt_q + REF_W'(1);
                end
                an_d  = 4'hF ^ (4'(1) << idx_q);
                seg_d = {~snap_q.dp[idx_q], glyph_c};
            end
        endcase

        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_on_d  = 1'b1;
        end else if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
        end

        // Off phase only masks the outputs; scanning keeps running underneath
        if (blink_en && !phase_on_q) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            ref_cnt_q   <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            an_q        <= 4'hF;
            seg_q       <= 8'hFF;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: doc/timer_display_driver.md
Name: timer_display_driver

Overview:
Downstream display stage for the count-down timer. Takes the four BCD digits (minute MSD/LSD, second MSD/LSD) from the timer core and drives the four-digit common-anode 7-segment display on the Basys3. It time-multiplexes the digits, decodes BCD to segments, lights the decimal point per digit, blanks leading zeros, and blinks the whole display when the count-down completes. Inputs are snapshotted once per frame so a value never changes mid-frame.

Parameters:
REFRESH_DIV, 2500, clk cycles each digit is held (5 MHz / 2500 = 2 kHz digit rate, 500 Hz frame)
BLINK_DIV, 2500000, clk cycles per blink half-period (0.5 s at 5 MHz)

Ports:
clk  input  1  system clock (5 MHz domain)
reset  input  1  asynchronous, active-high reset
digit3  input  4  BCD, leftmost digit (minute MSD)
digit2  input  4  BCD (minute LSD)
digit1  input  4  BCD (second MSD)
digit0  input  4  BCD, rightmost digit (second LSD)
dp_mask  input  4  bit i=1 lights the DP of digit i
blank_lz  input  1  1 = blank leading zeros
blink_en  input  1  1 = blink display (count-down done)
an  output  4  digit enables, active low, registered
seg  output  8  {dp,g,f,e,d,c,b,a}, active low, registered

Behaviour:
- Reset (async): an=4'b1111, seg=8'hFF, ref_cnt=0, idx=0, blink_cnt=0, blink_phase=ON, snapshot=0, state=INIT.
- Clock is the only clock; reset is asynchronous and active-high; all other logic is synchronous to rising clk.
- FSM INIT: in the first cycle after reset deasserts, load snapshot (digit3..0, dp_mask, blank_lz) and go to SCAN.
- FSM SCAN behaviour:
  - ref_cnt counts 0..REFRESH_DIV-1 and wraps.
  - At ref_cnt==REFRESH_DIV-1, idx advances mod 4 in the order 0,1,2,3,0.
  - When idx wraps 3->0, reload snapshot in the same cycle.
- Outputs are registered with 1-cycle latency from idx/snapshot.
  - an = ~(1<<idx): idx0=1110, idx1=1101, idx2=1011, idx3=0111.
- Decode (g..a, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10-15 show a dash: 0111111.
- Leading-zero blanking, applied only when snapshot blank_lz=1:
  - digit3 is blank if it is 0.
  - digit2 is blank if digit3 is blank and digit2 is 0.
  - digit1 is blank if digit2 is blank and digit1 is 0.
  - digit0 is never blanked.
  - A blank digit drives g..a=1111111.
- DP: seg[7] = ~dp_mask_snap[idx]. This applies even when the digit is blank.
- Blink:
  - While blink_en=0: blink_cnt=0 and phase=ON.
  - While blink_en=1: blink_cnt counts 0..BLINK_DIV-1; at the terminal count phase toggles and blink_cnt wraps.
  - Phase OFF forces an=1111 and seg=8'hFF. Scanning counters keep running underneath.
  - blink_en rising always starts in phase ON.
  - blink_en falling restores normal display on the next registered output.
- Async reset mid-frame: outputs go dark immediately; the block restarts through INIT.
- Input changes mid-frame have no effect until the next 3->0 wrap.
- REFRESH_DIV and BLINK_DIV must be >= 2. Counter widths are sized by $clog2.

Test Plan:
1. REFRESH_DIV=4, inputs 1,2,3,4 (digit3..0), dp_mask=0100, blank_lz=0; release reset.
   -> an sequence 1110/1101/1011/0111, 4 cycles each.
   -> seg: digit0 = 8'b10011001, digit1 = 8'b10110000, digit2 = 8'b00100100, digit3 = 8'b11111001.
2. digits 0,0,0,7, blank_lz=1.
   -> digits 3..1 seg=8'hFF; digit0 seg=8'b11111000.
   -> With digits 0,1,0,0: only digit3 is blank; digit1 shows 1000000.
3. Change digit0 from 5 to 6 while idx=1.
   -> digit0 keeps showing 5 until the frame after the next 3->0 wrap, then shows 6.
4. digit1=4'hC.
   -> digit1 seg g..a=0111111.
5. BLINK_DIV=32, assert blink_en.
   -> Normal display for 32 cycles, then an=1111/seg=FF for 32 cycles, repeating.
   -> Deassert blink_en in the OFF phase: display resumes next cycle.
6. Assert reset mid-scan.
   -> an=1111, seg=FF immediately (asynchronous).
   -> After release, the first output is an=1110 with the current inputs.
